jk_seq_driver: RTL
==================

// Module: jk_seq_driver
// PURPOSE
//  Inverse of a JK flip-flop: accepts a target next state and derives the J/K excitation that drives a bank of
//  WIDTH JK flip-flops to that state. Then checks that the bank actually reached the target.
//  Sits between a sequence source (valid/ready) and a JK register bank. Used to build arbitrary-sequence
//  counters from JK cells.
// PARAMETERS
//  WIDTH  4  number of JK bits in the bank / width of target word
//  CNT_W  8  width of completed-step counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, synchronous, active-high
//  tgt_valid  in   1      target word valid
//  tgt_ready  out  1      block can accept target (high only in IDLE)
//  tgt_data   in   WIDTH  requested next state of bank
//  hold_mask  in   WIDTH  1 = bit frozen (J=K=0 forced), sampled at handshake
//  err_clr    in   1      clears sticky err
//  j_out      out  WIDTH  registered J excitation applied to bank
//  k_out      out  WIDTH  registered K excitation applied to bank
//  q          out  WIDTH  current bank state
//  step_done  out  1      one-cycle pulse: a step finished
//  step_cnt   out  CNT_W  count of completed steps
//  err        out  1      sticky: bank did not reach target
// BEHAVIOUR
//  Reset values: q=0, j_out=0, k_out=0, step_done=0, step_cnt=0, err=0, state=IDLE, tgt_ready=1.
//  rst has priority in every state; reset mid-step abandons the step, with no step_done and no count.
//  FSM: IDLE -> DRIVE -> VERIFY -> IDLE, one cycle each outside IDLE.
//   IDLE: tgt_ready=1. On tgt_valid&tgt_ready, register tgt_reg<=tgt_data and set j_out/k_out from q,
//         tgt_data and hold_mask, then go to DRIVE. With no handshake, stay in IDLE and hold all outputs.
//   DRIVE: bank clock-enable=1. At the closing edge each bit takes q <= (j&~q)|(~k&q).
//   VERIFY: compare q with tgt_reg. Set step_done<=1 and step_cnt<=step_cnt+1 (wraps 2^CNT_W-1 -> 0).
//         On mismatch set err<=1. Then go to IDLE.
//  Timing: handshake in cycle N; q updated and visible in N+2; step_done=1 in N+3; next accept earliest N+3.
//  Excitation per bit (q->t): 0->0 J=0 K=x; 0->1 J=1 K=x; 1->0 J=x K=1; 1->1 J=x K=0.
//   Default don't-care resolution: x=0, so the bank uses set/reset only.
//   hold_mask bit=1 forces J=K=0 on that bit regardless of target. A differing target on that bit gives err.
//  Bank holds (clock-enable=0) in IDLE and VERIFY. j_out/k_out keep last value until the next handshake.
//  err_clr with a VERIFY mismatch in the same cycle: set wins, err=1. Otherwise err_clr gives err<=0 next edge.
//  tgt_data equal to q is a legal step: J=K=0, no change, step counts, no err.
//  tgt_valid held high continuously: one step accepted per 3 cycles. tgt_data is ignored outside IDLE.
// CONFIGURATION
//  JK_TOGGLE_DC_EN defined: don't-care resolved to 1. 0->1 drives J=1 K=1, 1->0 drives J=1 K=1,
//   0->0 drives J=0 K=1, 1->1 drives J=1 K=0. Resulting q is identical. Only j_out/k_out differ.
//  Not defined: x=0 as above.
// STRUCTURE
//  Package jk_seq_pkg: state enum {IDLE,DRIVE,VERIFY} (2-bit encoding).
//   The package also holds a function jk_excite(q,t,mask) returning {j,k} per bit, honouring JK_TOGGLE_DC_EN.
//  Sub-module jk_bit: one JK flip-flop with clk, rst (sync, ->0), ce, j, k, q.
//   Instantiated WIDTH times via generate.
//  Top: FSM, tgt_reg, excitation registers, counter, err flag, compare.
// TESTING
//  1 Reset 2 cycles, then tgt_data=4'hA -> accepted in IDLE; j_out=A, k_out=0; q=4'hA in N+2; step_done pulse
//    in N+3; step_cnt=1; err=0.
//  2 From q=A send 4'h5 -> j_out=5, k_out=A (default) or j_out=F, k_out=F (JK_TOGGLE_DC_EN); q=5; no err.
//  3 hold_mask=4'h1 with q=0, target 4'h3 -> q=4'h2, err=1. Then err_clr=1 -> err=0 next cycle.
//  4 tgt_valid held high with targets 1,2,3,... -> tgt_ready high 1 cycle in 3; q follows the sequence.
//    step_cnt with CNT_W=2 wraps 3->0 on the 4th step.
//  5 Assert rst in DRIVE -> next cycle q=0, state IDLE, no step_done, step_cnt unchanged (0 after reset).
//  6 err_clr asserted in the same VERIFY cycle as a mismatch -> err=1 (set wins).

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and J/K excitation for the JK sequence driver.
// Optional macro JK_TOGGLE_DC_EN resolves excitation don't-cares to 1 instead of 0.
package jk_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      VERIFY = 2'd2
   } state_t;

   // Returns {j, k} that moves one JK cell from q to t; a held bit gets J=K=0.
   function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic mask);
      logic j;
      logic k;
      j = 1'b0;
      k = 1'b0;
      if (!mask) begin
`ifdef JK_TOGGLE_DC_EN
         j = q | t;
         k = ~(q & t);
`else
         j = ~q & t;
         k = q & ~t;
`endif
      end
      return {j, k};
   endfunction

endpackage

// File: rtl/jk_seq_driver_jk_bit.sv
// Single JK flip-flop with synchronous active-high reset to 0 and clock enable.
module jk_bit (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else if (ce) begin
         q <= (j & ~q) | (~k & q);
      end
   end

endmodule

// File: rtl/jk_seq_driver.sv
// Derives J/K excitation for a WIDTH-bit JK bank from a target word, steps the bank, and verifies it.
// Optional macro JK_TOGGLE_DC_EN: don't-care excitation resolved to 1 (see jk_seq_pkg).
module jk_seq_driver
   import jk_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] hold_mask,
   input  logic             err_clr,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic [WIDTH-1:0] q,
   output logic             step_done,
   output logic [CNT_W-1:0] step_cnt,
   output logic             err
);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             bank_ce;
   logic             mismatch;
   logic [WIDTH-1:0] tgt_reg;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      tgt_ready  = 1'b0;
      accept     = 1'b0;
      bank_ce    = 1'b0;
      case (state)
         IDLE: begin
            tgt_ready = 1'b1;
            accept    = tgt_valid;
            if (tgt_valid) begin
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            bank_ce    = 1'b1;
            state_next = VERIFY;
         end
         VERIFY:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      j_next = '0;
      k_next = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         {j_next[i], k_next[i]} = jk_excite(q[i], tgt_data[i], hold_mask[i]);
      end
   end

   assign mismatch = (q != tgt_reg);

   // A mismatch in VERIFY outranks err_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_reg   <= '0;
         j_out     <= '0;
         k_out     <= '0;
         step_done <= 1'b0;
         step_cnt  <= '0;
         err       <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (accept) begin
            tgt_reg <= tgt_data;
            j_out   <= j_next;
            k_out   <= k_next;
         end
         if (state == VERIFY) begin
            step_done <= 1'b1;
            step_cnt  <= step_cnt + CNT_W'(1);
         end
         if (state == VERIFY && mismatch) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bank
      jk_bit u_bit (
         .clk (clk),
         .rst (rst),
         .ce  (bank_ce),
         .j   (j_out[i]),
         .k   (k_out[i]),
         .q   (q[i])
      );
   end

endmodule
